// File: rtl/wb_stage_pipe_if.sv
// Writeback-stage bus: upstream result entry, stall/flush controls and the
// register-file write port.
interface wb_stage_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             hold;
  logic             flush;
  logic [WIDTH-1:0] data_in;
  logic [1:0]       addr_lo;
  logic [4:0]       rd;
  logic [5:0]       func;
  logic             we;
  logic [4:0]       rd_out;
  logic [WIDTH-1:0] data_out;
  logic             misalign;

  modport master (
    output in_valid, hold, flush, data_in, addr_lo, rd, func,
    input  in_ready, we, rd_out, data_out, misalign
  );

  modport slave (
    input  in_valid, hold, flush, data_in, addr_lo, rd, func,
    output in_ready, we, rd_out, data_out, misalign
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Writeback stage: load alignment/extension, DEPTH-deep valid-tracked
// pipeline with hold and flush, x0 write suppression, misaligned-load flag
// and a committed-write counter.
// Func encoding: 0 unknown, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5..10 branches,
// 11 LB, 12 LH, 13 LW, 14 LBU, 15 LHU, 16..18 stores, 19..27 ADDI..SRAI,
// 28..37 ADDr..ANDr, 38..63 unknown.
module wb_stage_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_pipe_if.slave   bus,
  output logic [CNT_W-1:0] wr_count
);

  localparam int unsigned LAST = DEPTH - 1;

  localparam logic [5:0] F_LUI  = 6'd1;
  localparam logic [5:0] F_JALR = 6'd4;
  localparam logic [5:0] F_LB   = 6'd11;
  localparam logic [5:0] F_LH   = 6'd12;
  localparam logic [5:0] F_LW   = 6'd13;
  localparam logic [5:0] F_LBU  = 6'd14;
  localparam logic [5:0] F_LHU  = 6'd15;
  localparam logic [5:0] F_ADDI = 6'd19;
  localparam logic [5:0] F_ANDR = 6'd37;

  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [WIDTH-1:0] aligned;
  logic             mis_in;
  logic             accept;
  logic             out_writes;

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] mis;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [4:0]       rdq [DEPTH];
  logic [5:0]       fnq [DEPTH];

  // Select and extend load data, and flag misaligned accesses.
  always_comb begin
    sel_byte = bus.data_in[7:0];
    case (bus.addr_lo)
      2'd1:    sel_byte = bus.data_in[15:8];
      2'd2:    sel_byte = bus.data_in[23:16];
      2'd3:    sel_byte = bus.data_in[31:24];
      default: sel_byte = bus.data_in[7:0];
    endcase
    sel_half = bus.addr_lo[1] ? bus.data_in[31:16] : bus.data_in[15:0];
    aligned  = bus.data_in;
    case (bus.func)
      F_LB:    aligned = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
      F_LBU:   aligned = {{(WIDTH-8){1'b0}}, sel_byte};
      F_LH:    aligned = {{(WIDTH-16){sel_half[15]}}, sel_half};
      F_LHU:   aligned = {{(WIDTH-16){1'b0}}, sel_half};
      default: aligned = bus.data_in;
    endcase
    mis_in = (((bus.func == F_LH) || (bus.func == F_LHU)) && bus.addr_lo[0]) ||
             ((bus.func == F_LW) && (bus.addr_lo != 2'd0));
  end

  assign accept = bus.in_valid && !bus.hold && !bus.flush;

  // Stage shift register; flush clears valid bits even while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      mis <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat[k] <= '0;
        rdq[k] <= '0;
        fnq[k] <= '0;
      end
    end else begin
      if (!bus.hold) begin
        vld[0] <= accept;
        if (accept) begin
          dat[0] <= aligned;
          rdq[0] <= bus.rd;
          fnq[0] <= bus.func;
          mis[0] <= mis_in;
        end
        for (int k = 1; k < DEPTH; k++) begin
          vld[k] <= vld[k-1];
          mis[k] <= mis[k-1];
          dat[k] <= dat[k-1];
          rdq[k] <= rdq[k-1];
          fnq[k] <= fnq[k-1];
        end
      end
      if (bus.flush) begin
        vld <= '0;
      end
    end
  end

  // Does the output-stage func write the register file.
  always_comb begin
    out_writes = fnq[LAST] inside {[F_LUI:F_JALR], [F_LB:F_LHU], [F_ADDI:F_ANDR]};
  end

  assign bus.in_ready = !bus.hold;
  assign bus.we       = vld[LAST] && !bus.hold && out_writes && (rdq[LAST] != 5'd0);
  assign bus.rd_out   = rdq[LAST];
  assign bus.data_out = dat[LAST];
  assign bus.misalign = vld[LAST] && mis[LAST];

  // Committed-write counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if (bus.we) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

endmodule
